// File: rtl/tdm_demux_16_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux_16_pkg
// Shared definitions for the 16-channel serial TDM demultiplexer:
//   NUM_CHAN   - number of TDM channels per frame (16)
//   CHAN_W     - width of the channel index (4)
//   CHAN_*     - sized channel-index constants used by the counter and FSM
//   state_e    - framing FSM states {HUNT, RUN}
// No ports (package).
// -----------------------------------------------------------------------------
package tdm_demux_16_pkg;

   localparam int unsigned NUM_CHAN = 16;
   localparam int unsigned CHAN_W   = 4;

   localparam logic [CHAN_W-1:0] CHAN_ZERO = 4'd0;
   localparam logic [CHAN_W-1:0] CHAN_ONE  = 4'd1;
   localparam logic [CHAN_W-1:0] CHAN_LAST = 4'd15;

   // HUNT: waiting for a sync-marked strobe; RUN: frame-aligned
   typedef enum logic [0:0] {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage : tdm_demux_16_pkg

// File: rtl/tdm_demux_16_chan_counter.sv
// -----------------------------------------------------------------------------
// tdm_chan_counter
// Channel index counter for the TDM demultiplexer with wrap detection.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   synchronous active-high reset (index -> 0)
//   load1_i  in   force index to 1 (channel 0 was just written by a sync strobe)
//   inc_i    in   advance index by one, wrapping 15 -> 0
//   chan_o   out  current channel index (next bit is written here)
//   last_o   out  high while the index is 15 (next strobe completes a frame)
// load1_i has priority over inc_i.
// -----------------------------------------------------------------------------
module tdm_chan_counter
   import tdm_demux_16_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load1_i,
   input  logic              inc_i,
   output logic [CHAN_W-1:0] chan_o,
   output logic              last_o
);

   logic [CHAN_W-1:0] chan_q;
   logic [CHAN_W-1:0] chan_d;

   // Next index: resync load wins over a normal increment; 15+1 wraps to 0
   always_comb begin
      chan_d = chan_q;
      if (load1_i) begin
         chan_d = CHAN_ONE;
      end else if (inc_i) begin
         chan_d = chan_q + CHAN_ONE;
      end else begin
         chan_d = chan_q;
      end
   end

   // Index register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         chan_q <= CHAN_ZERO;
      end else begin
         chan_q <= chan_d;
      end
   end

   assign chan_o = chan_q;
   assign last_o = (chan_q == CHAN_LAST);

endmodule : tdm_chan_counter

// File: rtl/tdm_demux_16.sv
// -----------------------------------------------------------------------------
// tdm_demux_16
// Serial 16-channel TDM demultiplexer. Bits arrive on din_i one per en_i
// strobe; sync_i marks the channel-0 bit. Bits collect in a shadow register
// and the whole frame is published on q_o only once channel 15 arrives, so a
// partial frame never appears on q_o.
// Ports:
//   clk_i          in   clock, rising edge
//   rst_i          in   synchronous active-high reset, priority over all inputs
//   din_i          in   serial TDM data bit
//   sync_i         in   frame marker (channel-0 bit)
//   en_i           in   bit strobe; din_i/sync_i ignored when low
//   q_o[15:0]      out  last complete frame, q_o[i] = channel i
//   frame_valid_o  out  one-cycle pulse in the cycle q_o takes a new frame
//   chan_o[3:0]    out  channel the next strobed bit is written to
//   sync_err_o     out  one-cycle pulse on a sync seen away from channel 0
// Configuration macro:
//   TDM_DEMUX_SYNC_CHECK_EN - when defined, a sync strobe in RUN with a
//   non-zero channel index raises sync_err_o and resynchronises the frame.
//   When undefined, sync_i is ignored in RUN and sync_err_o stays 0.
// -----------------------------------------------------------------------------
module tdm_demux_16
   import tdm_demux_16_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                din_i,
   input  logic                sync_i,
   input  logic                en_i,
   output logic [NUM_CHAN-1:0] q_o,
   output logic                frame_valid_o,
   output logic [CHAN_W-1:0]   chan_o,
   output logic                sync_err_o
);

   state_e              state_q, state_d;
   logic [NUM_CHAN-1:0] shadow_q, shadow_d;
   logic [NUM_CHAN-1:0] q_q, q_d;
   logic                fv_q, fv_d;
   logic                err_q, err_d;

   logic [CHAN_W-1:0]   chan_s;
   logic                last_s;
   logic                load1_s;
   logic                inc_s;
   logic                resync_s;

   tdm_chan_counter u_chan_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load1_i (load1_s),
      .inc_i   (inc_s),
      .chan_o  (chan_s),
      .last_o  (last_s)
   );

`ifdef TDM_DEMUX_SYNC_CHECK_EN
   // sync at channel 0 is correct alignment; anywhere else is misplaced
   assign resync_s = sync_i && (chan_s != CHAN_ZERO);
`else
   assign resync_s = 1'b0;
`endif

   // Framing FSM next state, shadow capture and frame publish
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      q_d      = q_q;
      fv_d     = 1'b0;
      err_d    = 1'b0;
      load1_s  = 1'b0;
      inc_s    = 1'b0;
      if (en_i) begin
         case (state_q)
            HUNT: begin
               if (sync_i) begin
                  shadow_d[0] = din_i;
                  load1_s     = 1'b1;
                  state_d     = RUN;
               end else begin
                  state_d = HUNT;
               end
            end
            RUN: begin
               if (resync_s) begin
                  // Drop the partial frame and restart at channel 1
                  err_d    = 1'b1;
                  shadow_d = {{(NUM_CHAN-1){1'b0}}, din_i};
                  load1_s  = 1'b1;
               end else begin
                  shadow_d[chan_s] = din_i;
                  inc_s            = 1'b1;
                  if (last_s) begin
                     // Bit 15 goes straight to q; shadow_q[15] is stale here
                     q_d  = {din_i, shadow_q[NUM_CHAN-2:0]};
                     fv_d = 1'b1;
                  end else begin
                     q_d = q_q;
                  end
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State, shadow and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= HUNT;
         shadow_q <= {NUM_CHAN{1'b0}};
         q_q      <= {NUM_CHAN{1'b0}};
         fv_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         q_q      <= q_d;
         fv_q     <= fv_d;
         err_q    <= err_d;
      end
   end

   assign q_o           = q_q;
   assign frame_valid_o = fv_q;
   assign chan_o        = chan_s;
   assign sync_err_o    = err_q;

endmodule : tdm_demux_16

// File: doc/tdm_demux_16.md
TDM_DEMUX_16 -- requirements
Module: tdm_demux_16

Interface
REQ-001 The block SHALL have no parameters; the channel count is fixed at 16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 din  input  1  serial TDM data bit.
REQ-005 sync  input  1  frame marker; high marks the channel-0 bit.
REQ-006 en  input  1  bit strobe; din/sync sampled only when high.
REQ-007 q  output  16  last complete frame; q[i] is channel i.
REQ-008 frame_valid  output  1  one-cycle pulse when q updates.
REQ-009 chan  output  4  channel index the next strobed bit is written to.
REQ-010 sync_err  output  1  one-cycle pulse on misplaced sync.

Function
REQ-011 The FSM SHALL have two states: HUNT (waiting for sync) and RUN.
REQ-012 In HUNT, en=1 with sync=0 SHALL be ignored; en=1 with sync=1 SHALL write din to shadow[0], set chan=1 and enter RUN.
REQ-013 In RUN, en=1 SHALL write din to shadow[chan] and increment chan modulo 16.
REQ-014 en=0 SHALL hold all state; frame_valid and sync_err SHALL be 0.
REQ-015 On the strobe with chan=15, q SHALL load {din, shadow[14:0]} and frame_valid SHALL be 1 on the following cycle, with q valid in that same cycle.
REQ-016 After chan wraps to 0, the FSM SHALL stay in RUN; sync=1 on a chan=0 strobe is correct alignment and SHALL not raise an error.
REQ-017 q SHALL hold its value between frames; partial frames SHALL never reach q.
REQ-018 Back-to-back strobes (en=1 every cycle) SHALL be supported at one bit per clock with no bubbles.
REQ-019 frame_valid and sync_err SHALL be registered outputs with a pulse width of exactly one clk.

Reset
REQ-020 rst SHALL force state=HUNT, chan=0, q=16'h0000, shadow=0, frame_valid=0 and sync_err=0 on the next edge.
REQ-021 rst mid-frame SHALL discard the partial frame; rst SHALL take priority over en and sync in the same cycle.

Configuration
REQ-022 With TDM_DEMUX_SYNC_CHECK_EN defined, an en=1 and sync=1 strobe in RUN with chan!=0 SHALL pulse sync_err, discard the partial frame, write din to shadow[0] and set chan=1 (resynchronise).
REQ-023 Without TDM_DEMUX_SYNC_CHECK_EN, sync SHALL be ignored in RUN and sync_err SHALL be tied to 0.

Structure
REQ-024 A shared package SHALL hold the channel-count constant (16), the index width (4) and the state enumeration {HUNT, RUN}.
REQ-025 The index counter with wrap detection SHALL be a sub-module named tdm_chan_counter; the shadow register, q and FSM stay in tdm_demux_16.

Verification
REQ-026 Apply rst, then send sync on the first of 16 strobes carrying bits 0101010101010101 (LSB first) -> q=16'h5555 with frame_valid=1 for one cycle after the 16th strobe.
REQ-027 Send strobes with sync=0 in HUNT, then sync plus 16 bits 16'hA5C3 -> extra strobes are ignored, q=16'hA5C3, exactly one frame_valid pulse.
REQ-028 Send two frames 16'h1234 and 16'hFFFF back-to-back with en=1 continuously -> frame_valid pulses 16 clocks apart, q=16'h1234 then 16'hFFFF, sync_err=0.
REQ-029 With the macro defined, send sync at chan=7 -> sync_err pulses once, q is unchanged, chan=1; the next 15 strobes complete a new frame.
REQ-030 Assert rst at chan=9 with en held low for gaps -> q=0 and chan=0; a new frame completes only after the next sync.
REQ-031 Without the macro, repeat REQ-029 stimulus -> sync_err stays 0 and bit 7 lands in q[7] of the current frame.
